// File: rtl/bnn_class_vote_pkg.sv
// Shared constants and types for the BNN class-vote block.
// Class count and state encodings match the ones used by the BNN core.
package bnn_class_vote_pkg;

    localparam int unsigned NUM_CLASSES = 4;
    localparam int unsigned WINDOW      = 16;
    localparam int unsigned CLS_W       = $clog2(NUM_CLASSES);
    localparam int unsigned CNT_W       = $clog2(WINDOW + 1);
    localparam int unsigned FRM_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic [CNT_W-1:0] conf;
        logic             tie;
        logic             none;
    } vote_result_t;

endpackage

// File: rtl/bnn_class_vote_if.sv
// Frame input handshake and decision output bundle of the class-vote block.
interface bnn_class_vote_if;
    import bnn_class_vote_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_CLASSES-1:0] class_bits;
    logic                   out_valid;
    logic [CLS_W-1:0]       out_class;
    logic [CNT_W-1:0]       out_conf;
    logic                   out_tie;
    logic                   out_none;

    modport master (
        output in_valid, class_bits,
        input  in_ready, out_valid, out_class, out_conf, out_tie, out_none
    );

    modport slave (
        input  in_valid, class_bits,
        output in_ready, out_valid, out_class, out_conf, out_tie, out_none
    );

endinterface

// File: rtl/bnn_vote_counter.sv
// Per-class vote counter; clear has priority over increment.
module bnn_vote_counter
    import bnn_class_vote_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bnn_class_vote.sv
// Accumulates per-class votes over a window of frames, then scans the
// counts one class per cycle and publishes the argmax decision.
module bnn_class_vote
    import bnn_class_vote_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ena,
    input  logic            clear,
    bnn_class_vote_if.slave bus
);

    state_t             state;
    state_t             state_next;
    logic [FRM_W-1:0]   frame_cnt;
    logic [CLS_W-1:0]   idx;
    logic [CNT_W-1:0]   best_cnt;
    logic [CLS_W-1:0]   best_idx;
    logic               best_tie;
    logic [CNT_W-1:0]   cnt [NUM_CLASSES];
    vote_result_t       result;
    logic               valid_q;

    logic               accept;
    logic               scan_step;
    logic               scan_last;
    logic               cnt_clr;
    logic               last_frame;
    logic               idx_last;

    logic [CNT_W-1:0]   cur_cnt;
    logic               cur_gt;
    logic               cur_eq;
    logic [CNT_W-1:0]   best_cnt_n;
    logic [CLS_W-1:0]   best_idx_n;
    logic               best_tie_n;

    assign last_frame = (frame_cnt == FRM_W'(WINDOW - 1));
    assign idx_last   = (idx == CLS_W'(NUM_CLASSES - 1));

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cnt
        bnn_vote_counter u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (accept & bus.class_bits[c]),
            .clr   (cnt_clr),
            .count (cnt[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ena) begin
            if (clear) begin
                state_next = ST_ACCUM;
            end else begin
                case (state)
                    ST_ACCUM: if (accept && last_frame) state_next = ST_SCAN;
                    ST_SCAN:  if (idx_last)             state_next = ST_ACCUM;
                    default:                            state_next = ST_ACCUM;
                endcase
            end
        end
    end

    always_comb begin
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        scan_step    = 1'b0;
        scan_last    = 1'b0;
        cnt_clr      = 1'b0;
        if (ena) begin
            bus.in_ready = (state == ST_ACCUM);
            if (clear) begin
                cnt_clr = 1'b1;
            end else if (state == ST_ACCUM) begin
                accept = bus.in_valid;
            end else begin
                scan_step = 1'b1;
                scan_last = idx_last;
                cnt_clr   = idx_last;
            end
        end
    end

    // Running argmax step; strict > keeps the lowest index on ties.
    always_comb begin
        cur_cnt    = cnt[idx];
        cur_gt     = (cur_cnt > best_cnt);
        cur_eq     = (cur_cnt == best_cnt) && (idx != '0);
        best_cnt_n = cur_gt ? cur_cnt : best_cnt;
        best_idx_n = cur_gt ? idx : best_idx;
        best_tie_n = cur_gt ? 1'b0 : (cur_eq | best_tie);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            idx       <= '0;
            best_cnt  <= '0;
            best_idx  <= '0;
            best_tie  <= 1'b0;
            result    <= '0;
            valid_q   <= 1'b0;
        end else if (ena) begin
            valid_q <= 1'b0;
            if (clear) begin
                frame_cnt <= '0;
                idx       <= '0;
                best_cnt  <= '0;
                best_idx  <= '0;
                best_tie  <= 1'b0;
            end else begin
                if (accept) begin
                    if (last_frame) begin
                        frame_cnt <= '0;
                        idx       <= '0;
                        best_cnt  <= '0;
                        best_idx  <= '0;
                        best_tie  <= 1'b0;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                if (scan_step) begin
                    best_cnt <= best_cnt_n;
                    best_idx <= best_idx_n;
                    best_tie <= best_tie_n;
                    idx      <= scan_last ? '0 : idx + 1'b1;
                    if (scan_last) begin
                        result.cls  <= best_idx_n;
                        result.conf <= best_cnt_n;
                        result.tie  <= best_tie_n;
                        result.none <= (best_cnt_n == '0);
                        valid_q     <= 1'b1;
                    end
                end
            end
        end
    end

    // A pulse raised just before ena drops stays pending until ena returns.
    assign bus.out_valid = valid_q & ena;
    assign bus.out_class = result.cls;
    assign bus.out_conf  = result.conf;
    assign bus.out_tie   = result.tie;
    assign bus.out_none  = result.none;

endmodule

// File: tb/tb_bnn_class_vote.sv
// Self-checking bench for bnn_class_vote: directed window table, corner
// sequences and a randomized run against a frame-level argmax model.
module tb_bnn_class_vote;
    import bnn_class_vote_pkg::*;

    logic clk;
    logic reset;
    logic ena;
    logic clear;

    bnn_class_vote_if bus ();

    bnn_class_vote dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model state
    int   m_votes [NUM_CLASSES];
    int   m_n;
    int   m_scan;
    logic m_pend;
    int   p_class, p_conf;
    logic p_tie, p_none;
    int   e_class, e_conf;
    logic e_tie, e_none;

    int hs_cnt;
    int last_win_acc;

    typedef struct {
        logic [3:0] a;
        int         na;
        logic [3:0] b;
        int         nb;
        int         cls;
        int         conf;
        logic       tie;
        logic       none;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_decide();
        int mx;
        int nmx;
        mx = 0;
        nmx = 0;
        p_class = 0;
        for (int c = 0; c < NUM_CLASSES; c++)
            if (m_votes[c] > mx) begin
                mx = m_votes[c];
                p_class = c;
            end
        for (int c = 0; c < NUM_CLASSES; c++)
            if (m_votes[c] == mx) nmx++;
        p_conf = mx;
        p_tie  = (nmx > 1);
        p_none = (mx == 0);
    endtask

    task automatic model_step(input logic e, input logic cl, input logic v,
                              input logic [3:0] b, input logic rs);
        if (rs) begin
            foreach (m_votes[c]) m_votes[c] = 0;
            m_n = 0; m_scan = 0; m_pend = 1'b0;
            e_class = 0; e_conf = 0; e_tie = 1'b0; e_none = 1'b0;
            hs_cnt = 0;
        end else if (e) begin
            m_pend = 1'b0;
            if (cl) begin
                foreach (m_votes[c]) m_votes[c] = 0;
                m_n = 0; m_scan = 0;
                hs_cnt = 0;
            end else if (m_scan == 0) begin
                if (v) begin
                    for (int c = 0; c < NUM_CLASSES; c++) m_votes[c] += int'(b[c]);
                    m_n++;
                    if (m_n == WINDOW) begin
                        model_decide();
                        foreach (m_votes[c]) m_votes[c] = 0;
                        m_n = 0;
                        m_scan = NUM_CLASSES;
                    end
                end
            end else begin
                m_scan--;
                if (m_scan == 0) begin
                    e_class = p_class; e_conf = p_conf; e_tie = p_tie; e_none = p_none;
                    m_pend = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: drive, check against model, advance model at the edge.
    task automatic cyc(input logic e, input logic cl, input logic v, input logic [3:0] b,
                       input logic rs, output logic ov);
        ena = e; clear = cl; bus.in_valid = v; bus.class_bits = b; reset = rs;
        #2;
        chk("in_ready",  32'(bus.in_ready),  32'(e && (m_scan == 0)));
        chk("out_valid", 32'(bus.out_valid), 32'(m_pend && e));
        chk("out_class", 32'(bus.out_class), 32'(e_class));
        chk("out_conf",  32'(bus.out_conf),  32'(e_conf));
        chk("out_tie",   32'(bus.out_tie),   32'(e_tie));
        chk("out_none",  32'(bus.out_none),  32'(e_none));
        ov = bus.out_valid;
        if (bus.out_valid) begin
            last_win_acc = hs_cnt;
            hs_cnt = 0;
        end
        if (bus.in_ready && v && e && !cl) hs_cnt++;
        @(posedge clk);
        model_step(e, cl, v, b, rs);
        #1;
    endtask

    task automatic feed(input logic [3:0] b, input int n);
        logic ov;
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, b, 1'b0, ov);
    endtask

    // Idle until out_valid; returns cycles waited after the last accept edge.
    task automatic wait_decision(output int lat);
        logic ov;
        lat = 10;
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
            if (ov) begin
                lat = j;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov;
        int   lat;
        int   pulses;
        int   decisions;

        vecs[0] = '{4'b0100, 16, 4'b0000,  0, 2, 16, 1'b0, 1'b0};
        vecs[1] = '{4'b0001,  8, 4'b1000,  8, 0,  8, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 16, 4'b0000,  0, 0,  0, 1'b1, 1'b1};
        vecs[3] = '{4'b1111, 16, 4'b0000,  0, 0, 16, 1'b1, 1'b0};
        vecs[4] = '{4'b1010,  5, 4'b1000, 11, 3, 16, 1'b0, 1'b0};
        vecs[5] = '{4'b0110,  9, 4'b0100,  7, 2, 16, 1'b0, 1'b0};

        reset = 1'b1; ena = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.class_bits = '0;
        repeat (2) @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);

        // Directed window table
        foreach (vecs[i]) begin
            feed(vecs[i].a, vecs[i].na);
            feed(vecs[i].b, vecs[i].nb);
            wait_decision(lat);
            chk("tbl_latency", 32'(lat), 32'(4));
            chk("tbl_class",   32'(bus.out_class), 32'(vecs[i].cls));
            chk("tbl_conf",    32'(bus.out_conf),  32'(vecs[i].conf));
            chk("tbl_tie",     32'(bus.out_tie),   32'(vecs[i].tie));
            chk("tbl_none",    32'(bus.out_none),  32'(vecs[i].none));
            repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
        end

        // Reset in the middle of a scan
        feed(4'b1000, 16);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, ov);
        ena = 1'b1; reset = 1'b0; bus.in_valid = 1'b0; #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_class", 32'(bus.out_class), 32'(0));
        chk("rst_out_conf",  32'(bus.out_conf),  32'(0));
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
            if (ov) pulses++;
        end
        chk("rst_no_pulse", 32'(pulses), 32'(0));
        feed(4'b0010, 16);
        wait_decision(lat);
        chk("rst_restart_class", 32'(bus.out_class), 32'(1));
        chk("rst_restart_conf",  32'(bus.out_conf),  32'(16));

        // Clear mid-window; the frame offered with clear is dropped
        feed(4'b0010, 10);
        cyc(1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, ov);
        feed(4'b0001, 15);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
        chk("clr_no_early", 32'(ov), 32'(0));
        feed(4'b0001, 1);
        wait_decision(lat);
        chk("clr_latency", 32'(lat), 32'(4));
        chk("clr_class",   32'(bus.out_class), 32'(0));
        chk("clr_conf",    32'(bus.out_conf),  32'(16));
        chk("clr_tie",     32'(bus.out_tie),   32'(0));
        feed(4'b0010, 10);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ov);
        feed(4'b0011, 16);
        wait_decision(lat);
        chk("clr_carry_class", 32'(bus.out_class), 32'(0));
        chk("clr_carry_tie",   32'(bus.out_tie),   32'(1));

        // Clear aborts a scan in progress
        feed(4'b0100, 16);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, ov);
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
            if (ov) pulses++;
        end
        chk("clr_scan_pulses", 32'(pulses), 32'(0));
        chk("clr_scan_hold",   32'(bus.out_conf), 32'(16));

        // ena low mid-scan freezes the scan position
        feed(4'b1000, 16);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, ov);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, ov);
        wait_decision(lat);
        chk("ena_scan_latency", 32'(lat), 32'(2));
        chk("ena_scan_class",   32'(bus.out_class), 32'(3));

        // Randomized run: in_valid always high, ena toggling
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, ov);
        decisions = 0;
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 4) != 0, 1'b0, 1'b1, 4'($urandom), 1'b0, ov);
            if (ov) begin
                decisions++;
                chk("rnd_accepts_per_decision", 32'(last_win_acc), 32'(WINDOW));
            end
        end
        chk("rnd_enough_decisions", 32'(decisions > 20), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
